serial_digit_adder: RTL and testbench

- Digit-serial multi-bit adder controller; sits directly upstream of the team's 2-bit adder slice (full_adder) and consumes its outputs.
- Accepts two WIDTH-bit operands plus carry-in and feeds the slice one 2-bit digit per clock, LSB digit first.
- Registers the slice carry between digits, assembles the WIDTH-bit sum, and reports the final carry-out.
- Trades latency for area wherever wide adds are infrequent.

---
 rtl/serial_digit_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 18 +
 rtl/serial_digit_adder.sv | 114 +++++++++++
 tb/tb_serial_digit_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and constants for the digit-serial adder controller.
// The controller feeds the 2-bit full_adder slice one DIGIT_BITS digit per clock.
package serial_digit_adder_pkg;

    localparam int DIGIT_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// 2-bit adder slice: {o_carry, o_sum1, o_sum0} = {bitA1,bitA0} + {bitB1,bitB0} + carry.
module full_adder (
    input  logic bitA0,
    input  logic bitA1,
    input  logic bitB0,
    input  logic bitB1,
    input  logic carry,
    output logic o_sum0,
    output logic o_sum1,
    output logic o_carry
);

    logic [2:0] total;

    assign total = {1'b0, bitA1, bitA0} + {1'b0, bitB1, bitB0} + {2'b00, carry};
    assign {o_carry, o_sum1, o_sum0} = total;

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial WIDTH-bit adder: walks the operands LSB digit first through one
// 2-bit full_adder slice, carrying between digits in c_reg.
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int N     = WIDTH / DIGIT_BITS;
    localparam int CNT_W = $clog2(N) + 1;

    if (((WIDTH % DIGIT_BITS) != 0) || (WIDTH < DIGIT_BITS)) begin : g_width_check
        $error("serial_digit_adder: WIDTH must be even and at least 2");
    end

    state_t                  state_reg;
    logic [WIDTH-1:0]        shift_a_reg;
    logic [WIDTH-1:0]        shift_b_reg;
    logic [WIDTH-1:0]        acc_reg;
    logic [WIDTH-1:0]        acc_next;
    logic [WIDTH-1:0]        sum_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    c_reg;
    logic                    carry_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [DIGIT_BITS-1:0]   slice_sum;
    logic                    slice_carry;
    logic                    last_digit;

    full_adder u_slice (
        .bitA0   (shift_a_reg[0]),
        .bitA1   (shift_a_reg[1]),
        .bitB0   (shift_b_reg[0]),
        .bitB1   (shift_b_reg[1]),
        .carry   (c_reg),
        .o_sum0  (slice_sum[0]),
        .o_sum1  (slice_sum[1]),
        .o_carry (slice_carry)
    );

    // New digit enters at the top; after N shifts the whole sum sits in acc.
    assign acc_next   = (acc_reg >> DIGIT_BITS)
                      | (WIDTH'(slice_sum) << (WIDTH - DIGIT_BITS));
    assign last_digit = (cnt_reg == CNT_W'(N - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            shift_a_reg <= '0;
            shift_b_reg <= '0;
            acc_reg     <= '0;
            sum_reg     <= '0;
            cnt_reg     <= '0;
            c_reg       <= 1'b0;
            carry_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (i_start) begin
                        shift_a_reg <= i_a;
                        shift_b_reg <= i_b;
                        c_reg       <= i_carry;
                        cnt_reg     <= '0;
                        acc_reg     <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    shift_a_reg <= shift_a_reg >> DIGIT_BITS;
                    shift_b_reg <= shift_b_reg >> DIGIT_BITS;
                    acc_reg     <= acc_next;
                    c_reg       <= slice_carry;
                    cnt_reg     <= cnt_reg + CNT_W'(1);
                    if (last_digit) begin
                        sum_reg   <= acc_next;
                        carry_reg <= slice_carry;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_reg;
    assign o_done  = done_reg;
    assign o_sum   = sum_reg;
    assign o_carry = carry_reg;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed-table and sequence bench for serial_digit_adder at WIDTH=8 and WIDTH=2.
module tb_serial_digit_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, c8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       start2, c2, busy2, done2, carry2;
    logic [1:0] a2, b2, sum2;

    int tests;
    int fails;
    logic [7:0] prev_sum [2];
    logic       prev_c   [2];

    typedef struct {
        bit         w2;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs [14];

    serial_digit_adder #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
        .i_carry(c8), .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(carry8)
    );

    serial_digit_adder #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_a(a2), .i_b(b2),
        .i_carry(c2), .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_carry(carry2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit w2);
        return w2 ? done2 : done8;
    endfunction

    function automatic logic get_busy(input bit w2);
        return w2 ? busy2 : busy8;
    endfunction

    function automatic logic [7:0] get_sum(input bit w2);
        return w2 ? {6'b0, sum2} : sum8;
    endfunction

    function automatic logic get_carry(input bit w2);
        return w2 ? carry2 : carry8;
    endfunction

    task automatic drive(input bit w2, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        if (w2) begin
            start2 = s; a2 = a[1:0]; b2 = b[1:0]; c2 = c;
        end else begin
            start8 = s; a8 = a; b8 = b; c8 = c;
        end
    endtask

    // Waits (bounded) for o_done, checking busy and held result each RUN cycle.
    task automatic wait_done(input string tag, input bit w2, output int cyc);
        cyc = 1;
        while (!get_done(w2) && cyc <= 20) begin
            check({tag, " busy"}, 32'(get_busy(w2)), 32'd1);
            check({tag, " sum_hold"}, 32'(get_sum(w2)), 32'(prev_sum[w2]));
            check({tag, " carry_hold"}, 32'(get_carry(w2)), 32'(prev_c[w2]));
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_add(input string tag, input bit w2, input logic [7:0] a,
                           input logic [7:0] b, input logic c,
                           input logic [7:0] exp_s, input logic exp_c);
        int n;
        int cyc;
        n = w2 ? 1 : 4;
        drive(w2, 1'b1, a, b, c);
        @(posedge clk); #1;
        drive(w2, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        wait_done(tag, w2, cyc);
        check({tag, " latency"}, 32'(cyc), 32'(n + 1));
        check({tag, " sum"}, 32'(get_sum(w2)), 32'(exp_s));
        check({tag, " carry"}, 32'(get_carry(w2)), 32'(exp_c));
        check({tag, " busy_at_done"}, 32'(get_busy(w2)), 32'd0);
        $display("[TB] %s W%0d %h+%h+%0d -> sum=%h carry=%0d", tag, w2 ? 2 : 8,
                 a, b, c, get_sum(w2), get_carry(w2));
        prev_sum[w2] = exp_s;
        prev_c[w2]   = exp_c;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(get_done(w2)), 32'd0);
        check({tag, " idle_busy"}, 32'(get_busy(w2)), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full8;
        logic [2:0] full2;

        tests = 0;
        fails = 0;
        prev_sum[0] = 8'h00; prev_sum[1] = 8'h00;
        prev_c[0] = 1'b0; prev_c[1] = 1'b0;

        vecs[0]  = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6]  = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[8]  = '{1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
        vecs[9]  = '{1'b0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};
        vecs[10] = '{1'b1, 8'h03, 8'h03, 1'b1, 8'h03, 1'b1};
        vecs[11] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        vecs[12] = '{1'b1, 8'h02, 8'h02, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        #12;
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        check("rst sum8", 32'(sum8), 32'd0);
        check("rst carry8", 32'(carry8), 32'd0);
        check("rst busy2", 32'(busy2), 32'd0);
        check("rst sum2", 32'(sum2), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_add("tbl", vecs[i].w2, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co);
        end

        // Back-to-back with i_start held high; operands change in the DONE cycle.
        drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
        @(posedge clk); #1;
        wait_done("b2b first", 1'b0, cyc);
        check("b2b first latency", 32'(cyc), 32'd5);
        check("b2b first sum", 32'(sum8), 32'h03);
        check("b2b first carry", 32'(carry8), 32'd0);
        $display("[TB] b2b W8 01+02+0 -> sum=%h carry=%0d", sum8, carry8);
        prev_sum[0] = 8'h03; prev_c[0] = 1'b0;
        drive(1'b0, 1'b1, 8'h10, 8'h20, 1'b1);
        @(posedge clk); #1;
        check("b2b rerun busy", 32'(busy8), 32'd1);
        check("b2b rerun done", 32'(done8), 32'd0);
        drive(1'b0, 1'b0, 8'hC3, 8'h5A, 1'b0);
        @(posedge clk); #1;
        wait_done("b2b second", 1'b0, cyc);
        check("b2b second latency", 32'(cyc), 32'd4);
        check("b2b second sum", 32'(sum8), 32'h31);
        check("b2b second carry", 32'(carry8), 32'd0);
        $display("[TB] b2b W8 10+20+1 -> sum=%h carry=%0d", sum8, carry8);
        prev_sum[0] = 8'h31; prev_c[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b idle", 32'(busy8), 32'd0);

        // i_start pulsed during RUN cycle 2 must be ignored.
        drive(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'hAA, 8'h55, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) begin
                done_cnt++;
                check("ign sum", 32'(sum8), 32'h10);
                check("ign carry", 32'(carry8), 32'd0);
            end
            @(posedge clk); #1;
        end
        check("ign done count", 32'(done_cnt), 32'd1);
        check("ign idle", 32'(busy8), 32'd0);
        $display("[TB] ign W8 0F+01+0 -> sum=%h carry=%0d dones=%0d", sum8, carry8, done_cnt);
        prev_sum[0] = 8'h10; prev_c[0] = 1'b0;

        // Asynchronous reset in RUN cycle 2.
        drive(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("rst_mid busy before", 32'(busy8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy8), 32'd0);
        check("rst_mid done", 32'(done8), 32'd0);
        check("rst_mid sum", 32'(sum8), 32'd0);
        check("rst_mid carry", 32'(carry8), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done8) done_cnt++;
            @(posedge clk); #1;
        end
        check("rst_mid no done", 32'(done_cnt), 32'd0);
        $display("[TB] rst_mid W8 aborted, dones after release=%0d", done_cnt);
        prev_sum[0] = 8'h00; prev_c[0] = 1'b0;
        prev_sum[1] = 8'h00; prev_c[1] = 1'b0;
        run_add("rst_fresh", 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            run_add("rnd8", 1'b0, ra, rb, rc, full8[7:0], full8[8]);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(3, 0)); rb = 8'($urandom_range(3, 0)); rc = 1'($urandom);
            full2 = {1'b0, ra[1:0]} + {1'b0, rb[1:0]} + {2'b0, rc};
            run_add("rnd2", 1'b1, ra, rb, rc, {6'b0, full2[1:0]}, full2[2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
